// File: rtl/draw_sprite.sv
// draw_sprite: overlays a SPRITE_W x SPRITE_H bitmap, fetched from a
// synchronous sprite ROM, onto the incoming VGA timing/colour stream.
// The sprite position is sampled once per frame at the rising edge of
// vertical blanking so a moving sprite never tears mid-frame.
// All outputs carry the input stream delayed by exactly two clocks:
//   stage 1 - hit test and ROM address generation
//   stage 2 - colour-key compositing with the ROM pixel
module draw_sprite #(
  parameter int          SPRITE_W    = 100,
  parameter int          SPRITE_H    = 100,
  parameter logic [11:0] TRANSPARENT = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output logic [13:0] rom_addr,
  input  logic [11:0] rom_pixel,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  // ------------------------------------------------------------------
  // Frame-synchronous position latch
  // ------------------------------------------------------------------
  logic        r_vblnk_d;
  logic [11:0] r_x_lat;
  logic [11:0] r_y_lat;
  logic        w_vblnk_rise;

  // Rising edge of vertical blanking marks the start of the inter-frame gap.
  always_comb begin
    w_vblnk_rise = 1'b0;
    if (vblnk_in && !r_vblnk_d) begin
      w_vblnk_rise = 1'b1;
    end else begin
      w_vblnk_rise = 1'b0;
    end
  end

  // Capture xpos/ypos only on the vblnk rising edge; hold them otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vblnk_d <= 1'b0;
      r_x_lat   <= 12'd0;
      r_y_lat   <= 12'd0;
    end else begin
      r_vblnk_d <= vblnk_in;
      if (w_vblnk_rise) begin
        r_x_lat <= xpos;
        r_y_lat <= ypos;
      end else begin
        r_x_lat <= r_x_lat;
        r_y_lat <= r_y_lat;
      end
    end
  end

  // ------------------------------------------------------------------
  // Stage 1: hit test and ROM address
  // ------------------------------------------------------------------
  // Bounds are carried at 13 bits so a latched edge near 4095 plus the
  // sprite size does not wrap back onto the visible area.
  logic [12:0] w_h13;
  logic [12:0] w_v13;
  logic [12:0] w_x_lo;
  logic [12:0] w_y_lo;
  logic [12:0] w_x_hi;
  logic [12:0] w_y_hi;
  logic [12:0] w_dx;
  logic [12:0] w_dy;
  logic [13:0] w_addr;
  logic        w_in_x;
  logic        w_in_y;
  logic        w_hit;

  // Sprite-relative coordinates and the resulting hit/address.
  always_comb begin
    w_h13  = {2'b00, hcount_in};
    w_v13  = {2'b00, vcount_in};
    w_x_lo = {1'b0, r_x_lat};
    w_y_lo = {1'b0, r_y_lat};
    w_x_hi = w_x_lo + 13'(SPRITE_W);
    w_y_hi = w_y_lo + 13'(SPRITE_H);
    w_dx   = w_h13 - w_x_lo;
    w_dy   = w_v13 - w_y_lo;
    w_in_x = 1'b0;
    w_in_y = 1'b0;
    w_hit  = 1'b0;
    w_addr = 14'd0;

    if ((w_h13 >= w_x_lo) && (w_h13 < w_x_hi)) begin
      w_in_x = 1'b1;
    end else begin
      w_in_x = 1'b0;
    end

    if ((w_v13 >= w_y_lo) && (w_v13 < w_y_hi)) begin
      w_in_y = 1'b1;
    end else begin
      w_in_y = 1'b0;
    end

    // Blanking always masks the sprite, which also keeps the latch
    // update (only ever inside vblnk) away from any visible pixel.
    if (!hblnk_in && !vblnk_in && w_in_x && w_in_y) begin
      w_hit  = 1'b1;
      // Row-major address; offsets are below the sprite size inside a hit,
      // so the 14-bit truncation never loses a valid address.
      w_addr = ({1'b0, w_dy} * 14'(SPRITE_W)) + {1'b0, w_dx};
    end else begin
      w_hit  = 1'b0;
      w_addr = 14'd0;
    end
  end

  logic        r_hit_d1;
  logic [11:0] r_rgb_d1;
  logic [10:0] r_hcount_d1;
  logic [10:0] r_vcount_d1;
  logic        r_hsync_d1;
  logic        r_vsync_d1;
  logic        r_hblnk_d1;
  logic        r_vblnk_d1;

  // First pipeline stage: register address, hit flag and the VGA bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr    <= 14'd0;
      r_hit_d1    <= 1'b0;
      r_rgb_d1    <= 12'd0;
      r_hcount_d1 <= 11'd0;
      r_vcount_d1 <= 11'd0;
      r_hsync_d1  <= 1'b0;
      r_vsync_d1  <= 1'b0;
      r_hblnk_d1  <= 1'b0;
      r_vblnk_d1  <= 1'b0;
    end else begin
      rom_addr    <= w_addr;
      r_hit_d1    <= w_hit;
      r_rgb_d1    <= rgb_in;
      r_hcount_d1 <= hcount_in;
      r_vcount_d1 <= vcount_in;
      r_hsync_d1  <= hsync_in;
      r_vsync_d1  <= vsync_in;
      r_hblnk_d1  <= hblnk_in;
      r_vblnk_d1  <= vblnk_in;
    end
  end

  // ------------------------------------------------------------------
  // Stage 2: colour-key compositing
  // ------------------------------------------------------------------
  logic [11:0] w_rgb_mix;

  // ROM pixel wins only on a sprite hit and when it is not the colour key.
  always_comb begin
    w_rgb_mix = r_rgb_d1;
    if (r_hit_d1 && (rom_pixel != TRANSPARENT)) begin
      w_rgb_mix = rom_pixel;
    end else begin
      w_rgb_mix = r_rgb_d1;
    end
  end

  // Second pipeline stage: registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_out    <= 12'd0;
      hcount_out <= 11'd0;
      vcount_out <= 11'd0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
    end else begin
      rgb_out    <= w_rgb_mix;
      hcount_out <= r_hcount_d1;
      vcount_out <= r_vcount_d1;
      hsync_out  <= r_hsync_d1;
      vsync_out  <= r_vsync_d1;
      hblnk_out  <= r_hblnk_d1;
      vblnk_out  <= r_vblnk_d1;
    end
  end

endmodule

// File: tb/tb_draw_sprite.sv
// Directed testbench for draw_sprite: reset state, background passthrough,
// sprite corners, colour key, frame-synchronous latch, blanking/clipping
// and mid-frame reset.
module tb_draw_sprite;

  logic        clk;
  logic        rst;
  logic [10:0] hcount_in;
  logic [10:0] vcount_in;
  logic        hsync_in;
  logic        vsync_in;
  logic        hblnk_in;
  logic        vblnk_in;
  logic [11:0] rgb_in;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic [13:0] rom_addr;
  logic [11:0] rom_pixel;
  logic [10:0] hcount_out;
  logic [10:0] vcount_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        hblnk_out;
  logic        vblnk_out;
  logic [11:0] rgb_out;

  int n_checks = 0;
  int n_errors = 0;

  draw_sprite dut (
    .clk        (clk),
    .rst        (rst),
    .hcount_in  (hcount_in),
    .vcount_in  (vcount_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .hblnk_in   (hblnk_in),
    .vblnk_in   (vblnk_in),
    .rgb_in     (rgb_in),
    .xpos       (xpos),
    .ypos       (ypos),
    .rom_addr   (rom_addr),
    .rom_pixel  (rom_pixel),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .hblnk_out  (hblnk_out),
    .vblnk_out  (vblnk_out),
    .rgb_out    (rgb_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Produce a vblnk rising edge so the current xpos/ypos get latched.
  task automatic latch_pos(input logic [11:0] x, input logic [11:0] y);
    xpos     = x;
    ypos     = y;
    hblnk_in = 1'b1;
    vblnk_in = 1'b0;
    tick();
    vblnk_in = 1'b1;
    tick();
    vblnk_in = 1'b0;
    tick();
    tick();
  endtask

  // Present one pixel, check the address one cycle later, feed the ROM
  // pixel, then check the composited output two cycles after input.
  task automatic pix(input string tag, input logic [10:0] h, input logic [10:0] v,
                     input logic hb, input logic vb, input logic [11:0] rgb,
                     input logic [11:0] rp, input logic [13:0] exp_addr,
                     input logic [11:0] exp_rgb);
    hcount_in = h;
    vcount_in = v;
    hsync_in  = h[0];
    vsync_in  = v[0];
    hblnk_in  = hb;
    vblnk_in  = vb;
    rgb_in    = rgb;
    tick();
    chk({tag, ".rom_addr"}, 64'(rom_addr), 64'(exp_addr));
    rom_pixel = rp;
    tick();
    chk({tag, ".rgb_out"}, 64'(rgb_out), 64'(exp_rgb));
    chk({tag, ".timing"}, 64'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
        64'({h, v, h[0], v[0], hb, vb}));
  endtask

  logic [37:0] hist [0:63];
  logic [37:0] cur;
  logic [37:0] outv;

  initial begin
    rst       = 1'b1;
    hcount_in = 11'd123;
    vcount_in = 11'd45;
    hsync_in  = 1'b1;
    vsync_in  = 1'b1;
    hblnk_in  = 1'b1;
    vblnk_in  = 1'b1;
    rgb_in    = 12'hABC;
    xpos      = 12'd0;
    ypos      = 12'd0;
    rom_pixel = 12'h000;

    // Reset state: every output zero even with busy inputs.
    tick();
    tick();
    tick();
    chk("reset.rom_addr", 64'(rom_addr), 64'd0);
    chk("reset.outputs", 64'({rgb_out, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
        64'd0);
    rst      = 1'b0;
    vblnk_in = 1'b0;
    tick();

    // Background passthrough with the sprite parked off-screen.
    latch_pos(12'd2000, 12'd2000);
    for (int i = 0; i < 40; i++) begin
      hcount_in = 11'($urandom_range(1899, 0));
      vcount_in = 11'($urandom_range(1899, 0));
      hsync_in  = 1'($urandom_range(1, 0));
      vsync_in  = 1'($urandom_range(1, 0));
      hblnk_in  = 1'($urandom_range(1, 0));
      vblnk_in  = 1'($urandom_range(1, 0));
      rgb_in    = 12'($urandom_range(4095, 0));
      rom_pixel = 12'($urandom_range(4095, 0));
      hist[i]   = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in};
      tick();
      chk("pass.rom_addr", 64'(rom_addr), 64'd0);
      if (i >= 1) begin
        outv = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
        cur  = hist[i-1];
        chk("pass.bus", 64'(outv), 64'(cur));
      end
    end

    // Corner pixels of a sprite at (350,350).
    latch_pos(12'd350, 12'd350);
    pix("corner_tl",   11'd350, 11'd350, 1'b0, 1'b0, 12'h777, 12'h123, 14'd0,    12'h123);
    pix("corner_br",   11'd449, 11'd449, 1'b0, 1'b0, 12'h777, 12'h456, 14'd9999, 12'h456);
    pix("right_out",   11'd450, 11'd350, 1'b0, 1'b0, 12'h777, 12'h123, 14'd0,    12'h777);
    pix("bottom_out",  11'd350, 11'd450, 1'b0, 1'b0, 12'h777, 12'h123, 14'd0,    12'h777);
    pix("left_out",    11'd349, 11'd400, 1'b0, 1'b0, 12'h777, 12'h123, 14'd0,    12'h777);
    pix("corner_tr",   11'd449, 11'd350, 1'b0, 1'b0, 12'h777, 12'h321, 14'd99,   12'h321);

    // Colour key shows the background.
    pix("transparent", 11'd400, 11'd400, 1'b0, 1'b0, 12'h0A0, 12'hF0F, 14'd5050, 12'h0A0);

    // Position change mid-frame has no effect until the next vblnk rise.
    xpos = 12'd360;
    pix("latch_hold",  11'd350, 11'd360, 1'b0, 1'b0, 12'h111, 12'h222, 14'd1000, 12'h222);
    latch_pos(12'd360, 12'd350);
    pix("latch_new0",  11'd350, 11'd360, 1'b0, 1'b0, 12'h111, 12'h222, 14'd0,    12'h111);
    pix("latch_new1",  11'd360, 11'd360, 1'b0, 1'b0, 12'h111, 12'h333, 14'd1000, 12'h333);

    // Blanking inside the sprite area suppresses the overlay.
    pix("hblank",      11'd360, 11'd360, 1'b1, 1'b0, 12'h444, 12'h333, 14'd0,    12'h444);
    pix("vblank",      11'd361, 11'd361, 1'b0, 1'b1, 12'h555, 12'h333, 14'd0,    12'h555);

    // Latched top edge near 4095 must not wrap onto the top of the screen.
    latch_pos(12'd0, 12'd4090);
    pix("wrap_top",    11'd0,    11'd0,    1'b0, 1'b0, 12'h666, 12'h999, 14'd0, 12'h666);
    pix("wrap_mid",    11'd50,   11'd50,   1'b0, 1'b0, 12'h666, 12'h999, 14'd0, 12'h666);
    pix("wrap_bot",    11'd50,   11'd2047, 1'b0, 1'b0, 12'h666, 12'h999, 14'd0, 12'h666);

    // Mid-frame reset during a sprite line.
    latch_pos(12'd350, 12'd350);
    hcount_in = 11'd360;
    vcount_in = 11'd355;
    hsync_in  = 1'b1;
    vsync_in  = 1'b1;
    hblnk_in  = 1'b0;
    vblnk_in  = 1'b0;
    rgb_in    = 12'h0F0;
    tick();
    chk("prerst.rom_addr", 64'(rom_addr), 64'd510);
    rst = 1'b1;
    tick();
    chk("midrst.rom_addr", 64'(rom_addr), 64'd0);
    chk("midrst.outputs", 64'({rgb_out, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
        64'd0);
    rst = 1'b0;
    // Latch was cleared to (0,0): a pixel near the origin now hits.
    pix("postrst_hit", 11'd5,   11'd7,   1'b0, 1'b0, 12'h0F0, 12'hC0C, 14'd705, 12'hC0C);
    pix("postrst_old", 11'd360, 11'd355, 1'b0, 1'b0, 12'h0F0, 12'hC0C, 14'd0,   12'h0F0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
